prime_sieve_stream: RTL and testbench
=====================================

# prime_sieve_stream

Parametrised Sieve of Eratosthenes engine for the lab FPGA designs. On a `start` pulse it sieves all integers up to a run-time `limit` in an internal 1-bit-per-entry synchronous RAM, then streams the primes out in ascending order over a valid/ready interface. The display or formatter layer, e.g. the LCD row builder, consumes the stream. Compared with a fixed 1024-entry sieve, this block adds:
- a configurable table depth;
- a run-time limit;
- marking that starts at p·p;
- early termination of the outer loop;
- backpressured output;
- a restartable start/done handshake.

## Interface
Parameters:
- `N_MAX`, default 1024: table depth; the largest sievable value is N_MAX-1.
- `AW`, default 10: index width; must equal clog2(N_MAX).

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request. Sampled only in IDLE.
- `limit`  in  AW: inclusive upper bound. Captured on an accepted `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of a run.
- `prime_valid`  out  1: output stream valid.
- `prime_data`  out  AW: prime value. Stable while valid and not ready.
- `prime_ready`  in  1: consumer ready.
- `prime_count`  out  AW: primes handed over in the current or last run.

## Operation
- **Table.** The table is `N_MAX`×1 bits with synchronous read: the address presented in cycle t produces data in cycle t+1. There is one port, so a write and a read never occur in the same cycle. A bit value of 1 means "still candidate".
- **Run start.** A run begins on `start`=1 in IDLE. The block latches `limit` into `lim_r`, clears `prime_count` to 0, and enters INIT. A `start` asserted in any other state is ignored.
- **INIT.** Index i steps 0..lim_r, one per cycle. The block writes 0 for i<2 and 1 otherwise. After writing `lim_r` it moves to SCAN_RD with p=2. If `lim_r`<2, the block goes from INIT directly to DONE.
- **SCAN_RD.** If p·p > `lim_r`, the block moves to EMIT_RD with q=2. Otherwise it reads entry p and moves to SCAN_CHK. The comparison uses the full 2·AW-bit product.
- **SCAN_CHK.**
  - If the bit is 1: set m=p·p and go to MARK.
  - If the bit is 0: p←p+1 and go back to SCAN_RD.
- **MARK.** Each cycle the block writes 0 at m, then sets m←m+p. When the new m > `lim_r`, it sets p←p+1 and returns to SCAN_RD. The register m is AW+1 bits wide, so the sum never wraps.
- **EMIT_RD.** Reads entry q and moves to EMIT_CHK.
- **EMIT_CHK.**
  - If the bit is 1: load `prime_data`=q, assert `prime_valid`, and go to EMIT_OUT.
  - If the bit is 0: advance (see below).
- **EMIT_OUT.** Holds `prime_valid` and `prime_data` until `prime_ready`=1. On that handshake cycle it:
  - drops `prime_valid` on the next edge;
  - sets `prime_count`←`prime_count`+1;
  - advances (see below).
- **Advance.** If q == `lim_r`, go to DONE. Otherwise q←q+1 and go to EMIT_RD.
- **DONE.** Asserts `done` for one cycle, then returns to IDLE. `prime_count` holds its value until the next accepted `start`.
- **Out-of-range limit.** `limit` ≥ N_MAX cannot be encoded, because AW = clog2(N_MAX).

## Timing
- **Reset values.** `rst` has priority in any state, including mid-INIT, MARK or EMIT_OUT. The next state is IDLE, and all outputs are 0: `busy`, `done`, `prime_valid`, `prime_data`, `prime_count`. Table contents are don't-care, because INIT rewrites every used entry.
- **Busy.** `busy` rises in the cycle after `start` is accepted. It is low in IDLE only, so it is still high during the `done` cycle.
- **Cycle counts.**
  - INIT: `lim_r`+1 cycles.
  - Each prime candidate p: 2 cycles, plus ⌊(lim_r−p²)/p⌋+1 MARK cycles when p is prime.
  - Each emitted index: 2 cycles plus the handshake wait. With `prime_ready` tied high, a prime is delivered in 3 cycles and a composite costs 2 cycles.
- **Stream protocol.**
  - `prime_valid` never drops without a handshake.
  - `prime_data` never changes while `prime_valid` is high.
  - There is no combinational path from `prime_ready` to `prime_valid`.
- **Valid/done ordering.** The `done` cycle has `prime_valid`=0. `done` follows the last handshake by one cycle when that handshake occurs at q = `lim_r`, and later otherwise.

## Test plan
- `limit`=30, ready tied 1 → stream 2,3,5,7,11,13,17,19,23,29; `prime_count`=10; exactly one `done` pulse; `busy` low afterwards.
- `limit`=1023 (N_MAX=1024) → 172 primes; first is 2 and last is 1021; `prime_count`=172; the monotonic-increasing check passes.
- `limit`=100 with `prime_ready` driven by a pseudo-random generator (about 30% duty) → 25 primes with no duplicates or drops; `prime_data` stable while stalled.
- `limit`=1, then `limit`=2 → first run gives no `prime_valid` and count 0, with `done` pulsed; second run gives the single prime 2 and count 1.
- `rst` pulsed during MARK of a `limit`=500 run, then `start` with `limit`=10 → all outputs 0 on the cycle after reset; the second run yields 2,3,5,7 with count 4.
- `start` pulsed repeatedly while busy with `limit`=50 in flight → ignored; output equals the primes ≤50 (15 of them); no second run begins.

Source files
------------

// File: rtl/prime_sieve_stream_if.sv
// Start/limit request, done/busy status and the prime output stream of
// prime_sieve_stream, grouped into a single bundle.
interface prime_sieve_stream_if #(
    parameter int AW = 10
);
    logic          start;
    logic [AW-1:0] limit;
    logic          busy;
    logic          done;
    logic          prime_valid;
    logic [AW-1:0] prime_data;
    logic          prime_ready;
    logic [AW-1:0] prime_count;

    modport slave (
        input  start, limit, prime_ready,
        output busy, done, prime_valid, prime_data, prime_count
    );

    modport master (
        output start, limit, prime_ready,
        input  busy, done, prime_valid, prime_data, prime_count
    );
endinterface

// File: rtl/prime_sieve_stream.sv
// Sieve of Eratosthenes over a 1-bit-per-entry single-port table, streaming the
// primes up to a run-time limit in ascending order over valid/ready.
module prime_sieve_stream #(
    parameter int N_MAX = 1024,
    parameter int AW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    prime_sieve_stream_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_SCAN_RD,
        S_SCAN_CHK,
        S_MARK,
        S_EMIT_RD,
        S_EMIT_CHK,
        S_EMIT_OUT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_valid;
    logic [AW-1:0]   r_data;
    logic [AW-1:0]   r_count;
    logic [AW-1:0]   r_lim;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_p;
    logic [AW:0]     r_m;
    logic [AW-1:0]   r_q;

    logic            r_table [0:N_MAX-1];
    logic            r_rdata;

    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic            w_wdata;
    logic [2*AW-1:0] w_pp;
    logic [AW:0]     w_mNext;
    logic            w_ppOver;
    logic            w_qLast;

    // Full-width p*p so the outer-loop exit compare can never overflow.
    assign w_pp     = {{AW{1'b0}}, r_p} * {{AW{1'b0}}, r_p};
    assign w_ppOver = (w_pp > {{AW{1'b0}}, r_lim});
    assign w_mNext  = r_m + {1'b0, r_p};
    assign w_qLast  = (r_q == r_lim);

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = 1'b0;
        case (r_state)
            S_INIT: begin
                w_we    = 1'b1;
                w_addr  = r_idx;
                w_wdata = (r_idx >= AW'(2));
            end
            S_SCAN_RD: w_addr = r_p;
            S_MARK: begin
                w_we   = 1'b1;
                w_addr = r_m[AW-1:0];
            end
            S_EMIT_RD: w_addr = r_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_table[w_addr] <= w_wdata;
        end else begin
            r_rdata <= r_table[w_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
            r_lim   <= '0;
            r_idx   <= '0;
            r_p     <= '0;
            r_m     <= '0;
            r_q     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_lim   <= bus.limit;
                        r_count <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == r_lim) begin
                        if (r_lim < AW'(2)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_p     <= AW'(2);
                            r_state <= S_SCAN_RD;
                        end
                    end
                end
                S_SCAN_RD: begin
                    if (w_ppOver) begin
                        r_q     <= AW'(2);
                        r_state <= S_EMIT_RD;
                    end else begin
                        r_state <= S_SCAN_CHK;
                    end
                end
                S_SCAN_CHK: begin
                    if (r_rdata) begin
                        r_m     <= w_pp[AW:0];
                        r_state <= S_MARK;
                    end else begin
                        r_p     <= r_p + AW'(1);
                        r_state <= S_SCAN_RD;
                    end
                end
                S_MARK: begin
                    r_m <= w_mNext;
                    if (w_mNext > {1'b0, r_lim}) begin
                        r_p     <= r_p + AW'(1);
                        r_state <= S_SCAN_RD;
                    end
                end
                S_EMIT_RD: r_state <= S_EMIT_CHK;
                S_EMIT_CHK: begin
                    if (r_rdata) begin
                        r_data  <= r_q;
                        r_valid <= 1'b1;
                        r_state <= S_EMIT_OUT;
                    end else if (w_qLast) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_q     <= r_q + AW'(1);
                        r_state <= S_EMIT_RD;
                    end
                end
                S_EMIT_OUT: begin
                    if (bus.prime_ready) begin
                        r_valid <= 1'b0;
                        r_count <= r_count + AW'(1);
                        if (w_qLast) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_q     <= r_q + AW'(1);
                            r_state <= S_EMIT_RD;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.prime_valid = r_valid;
    assign bus.prime_data  = r_data;
    assign bus.prime_count = r_count;

endmodule

// File: tb/tb_prime_sieve_stream.sv
// Scoreboard bench: expected primes come from trial division and are popped by
// an independent monitor on every valid/ready handshake.
module tb_prime_sieve_stream;

    localparam int N_MAX = 1024;
    localparam int AW    = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prime_sieve_stream_if #(.AW(AW)) bus ();

    prime_sieve_stream #(.N_MAX(N_MAX), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors     = 0;
    int          checks     = 0;
    int          expQ[$];
    int          readyPct   = 100;
    int          doneCount  = 0;
    int          handshakes = 0;
    logic        lastValid  = 1'b0;
    logic        lastReady  = 1'b0;
    logic [AW-1:0] lastData = '0;

    function automatic bit isPrime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Consumer readiness re-rolled every cycle just after the rising edge.
    initial begin
        bus.prime_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.prime_ready = ($urandom_range(99) < readyPct);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            lastValid = 1'b0;
        end else begin
            if (lastValid && !lastReady) begin
                checkOutput("stall_valid_held", int'(bus.prime_valid), 1);
                checkOutput("stall_data_stable", int'(bus.prime_data), int'(lastData));
            end
            if (bus.done) begin
                doneCount++;
                checkOutput("done_cycle_valid_low", int'(bus.prime_valid), 0);
            end
            if (bus.prime_valid && bus.prime_ready) begin
                handshakes++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_prime", int'(bus.prime_data), -1);
                end else begin
                    checkOutput("prime_data", int'(bus.prime_data), expQ.pop_front());
                end
            end
            lastValid = bus.prime_valid;
            lastReady = bus.prime_ready;
            lastData  = bus.prime_data;
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_valid", int'(bus.prime_valid), 0);
        checkOutput("reset_data", int'(bus.prime_data), 0);
        checkOutput("reset_count", int'(bus.prime_count), 0);
    endtask

    task automatic pulseStart(input int lim);
        @(posedge clk);
        #1;
        bus.limit = AW'(lim);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busy_rise", int'(bus.busy), 1);
    endtask

    task automatic applyStimulus(input int lim, input int pct, input bit extraStarts);
        int expCount;
        int cycles;
        expCount = 0;
        for (int n = 2; n <= lim; n++) begin
            if (isPrime(n)) begin
                expQ.push_back(n);
                expCount++;
            end
        end
        readyPct   = pct;
        doneCount  = 0;
        handshakes = 0;
        pulseStart(lim);
        cycles = 0;
        while (doneCount == 0 && cycles < 30000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (extraStarts && bus.busy && ($urandom_range(3) == 0)) begin
                bus.limit = AW'($urandom_range(N_MAX - 1));
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (doneCount == 0) begin
            checkOutput("done_timeout", 0, 1);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("done_pulses", doneCount, 1);
        checkOutput("handshakes", handshakes, expCount);
        checkOutput("primes_left", expQ.size(), 0);
        checkOutput("prime_count", int'(bus.prime_count), expCount);
        checkOutput("busy_after", int'(bus.busy), 0);
        expQ.delete();
    endtask

    // Reset lands inside the p=2 marking pass of a limit=500 run.
    task automatic resetInMark();
        readyPct = 100;
        pulseStart(500);
        repeat (520) @(posedge clk);
        #1;
        checkOutput("busy_in_mark", int'(bus.busy), 1);
        doReset();
    endtask

    // Reset while a prime is held stalled on the output.
    task automatic resetInEmit();
        int cycles;
        readyPct   = 100;
        handshakes = 0;
        for (int n = 2; n <= 100; n++) begin
            if (isPrime(n)) expQ.push_back(n);
        end
        pulseStart(100);
        cycles = 0;
        while (handshakes < 5 && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        readyPct = 0;
        repeat (25) @(posedge clk);
        #1;
        checkOutput("emit_stalled_valid", int'(bus.prime_valid), 1);
        checkOutput("emit_count", int'(bus.prime_count), handshakes);
        doReset();
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.limit = '0;
        repeat (3) @(posedge clk);
        doReset();

        applyStimulus(30, 100, 1'b0);
        applyStimulus(1023, 100, 1'b0);
        applyStimulus(100, 30, 1'b0);
        applyStimulus(1, 100, 1'b0);
        applyStimulus(2, 100, 1'b0);
        resetInMark();
        applyStimulus(10, 100, 1'b0);
        applyStimulus(50, 100, 1'b1);
        for (int r = 0; r < 4; r++) begin
            applyStimulus($urandom_range(300), $urandom_range(100, 20), 1'b0);
        end
        resetInEmit();
        applyStimulus(0, 100, 1'b0);
        applyStimulus(3, 50, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
